// File: rtl/affine_pkg.sv
// Shared types and width constants for the switch-capture front end.
package affine;

   localparam int DB_W   = 8;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      VALID      = 2'd2,
      RELEASE_DB = 2'd3
   } capture_state_t;

endpackage

// File: rtl/sync2.sv
// Parameter-width two-flop synchronizer with a configurable reset value.
module sync2 #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta;

   // NOTE: sequential state uses non-blocking assignments so both flops sample the old values together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta <= RST_VAL;
         q_o  <= RST_VAL;
      end else begin
         meta <= d_i;
         q_o  <= meta;
      end
   end

endmodule

// File: rtl/sw_capture.sv
// Debounced push-button capture of the slide-switch operand with a valid/ack handshake.
module sw_capture
   import affine::*;
#(
   parameter int DB_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] sw_i,
   input  logic              key_n_i,
   input  logic              ack_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic [CNT_W-1:0]  cap_cnt_o
);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [DATA_W-1:0] sw_s;
   logic              key_s;

   sync2 #(.W(DATA_W), .RST_VAL('0)) u_sync_sw (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (sw_i),
      .q_o   (sw_s)
   );

   // Key synchronizer resets to 1 so the button reads as released.
   sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_key (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (key_n_i),
      .q_o   (key_s)
   );

   capture_state_t    state_q, state_d;
   logic [DB_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] data_d;
   logic              valid_d;
   logic [CNT_W-1:0]  cap_cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_o    <= '0;
         valid_o   <= 1'b0;
         cap_cnt_o <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_o    <= data_d;
         valid_o   <= valid_d;
         cap_cnt_o <= cap_cnt_d;
      end
   end

   // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_o;
      valid_d   = valid_o;
      cap_cnt_d = cap_cnt_o;

      unique case (state_q)
         IDLE: begin
            if (!key_s) begin
               state_d = PRESS_DB;
               cnt_d   = '0;
            end
         end
         PRESS_DB: begin
            if (key_s) begin
               state_d = IDLE;
            end else if (cnt_q == DB_LAST) begin
               state_d   = VALID;
               data_d    = sw_s;
               valid_d   = 1'b1;
               cap_cnt_d = cap_cnt_o + CNT_W'(1);
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
         VALID: begin
            // Operand is frozen here; only the acknowledge moves us on.
            if (ack_i) begin
               state_d = RELEASE_DB;
               valid_d = 1'b0;
               cnt_d   = '0;
            end
         end
         RELEASE_DB: begin
            if (!key_s) begin
               cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sw_capture.sv
// Directed self-checking bench for sw_capture with DB_CYCLES=4.
module tb_sw_capture;

   localparam int DB = 4;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] sw_i;
   logic       key_n_i;
   logic       ack_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic [3:0] cap_cnt_o;

   int checks   = 0;
   int failures = 0;

   sw_capture #(.DB_CYCLES(DB)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .sw_i      (sw_i),
      .key_n_i   (key_n_i),
      .ack_i     (ack_i),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .cap_cnt_o (cap_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Counts edges until valid_o is seen high; returns 0 when the budget runs out.
   task automatic wait_valid(input int budget, output int edges);
      edges = 0;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk_i);
         #1;
         if (valid_o) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic press(input logic [7:0] d);
      @(negedge clk_i);
      sw_i    = d;
      key_n_i = 1'b0;
   endtask

   task automatic release_key();
      @(negedge clk_i);
      key_n_i = 1'b1;
      step(DB + 6);
   endtask

   task automatic ack_pulse();
      @(negedge clk_i);
      ack_i = 1'b1;
      step(1);
      @(negedge clk_i);
      ack_i = 1'b0;
   endtask

   task automatic do_capture(input logic [7:0] d, input logic [3:0] exp_cnt);
      int e;
      press(d);
      wait_valid(20, e);
      check("loop_valid", {31'd0, valid_o}, 32'd1);
      check("loop_data", {24'd0, data_o}, {24'd0, d});
      check("loop_cnt", {28'd0, cap_cnt_o}, {28'd0, exp_cnt});
      ack_pulse();
      release_key();
   endtask

   initial begin
      int e;
      int stuck;
      rst_i   = 1'b1;
      sw_i    = 8'h00;
      key_n_i = 1'b1;
      ack_i   = 1'b0;
      step(3);
      check("rst_data", {24'd0, data_o}, 32'h00);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_cnt", {28'd0, cap_cnt_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      step(2);

      // Latency: valid_o must appear exactly DB+3 edges after key goes low.
      press(8'hA5);
      wait_valid(20, e);
      check("latency", e, DB + 3);
      check("cap1_data", {24'd0, data_o}, 32'hA5);
      check("cap1_cnt", {28'd0, cap_cnt_o}, 32'd1);
      step(13);
      check("cap1_hold", {31'd0, valid_o}, 32'd1);
      ack_pulse();
      check("ack1_valid", {31'd0, valid_o}, 32'd0);
      release_key();

      // Bounce: two short lows separated by one high cycle.
      @(negedge clk_i); key_n_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i); key_n_i = 1'b1;
      @(negedge clk_i); key_n_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i); key_n_i = 1'b1;
      step(15);
      check("bounce_valid", {31'd0, valid_o}, 32'd0);
      check("bounce_cnt", {28'd0, cap_cnt_o}, 32'd1);

      // Stray ack in IDLE must do nothing.
      ack_pulse();
      step(2);
      check("stray_ack_valid", {31'd0, valid_o}, 32'd0);
      check("stray_ack_cnt", {28'd0, cap_cnt_o}, 32'd1);

      // Capture 0x3C and hold without ack while the switches toggle.
      press(8'h3C);
      wait_valid(20, e);
      check("cap2_valid", {31'd0, valid_o}, 32'd1);
      stuck = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         sw_i = (i % 2 == 0) ? 8'hFF : 8'h00;
         @(posedge clk_i);
         #1;
         if (data_o !== 8'h3C || valid_o !== 1'b1) stuck++;
      end
      check("hold_errors", stuck, 0);
      check("cap2_data", {24'd0, data_o}, 32'h3C);
      check("cap2_cnt", {28'd0, cap_cnt_o}, 32'd2);
      ack_pulse();
      check("ack2_valid", {31'd0, valid_o}, 32'd0);
      check("ack2_data_kept", {24'd0, data_o}, 32'h3C);

      // Key remains held for 100 cycles after ack: no second capture.
      step(100);
      check("held_valid", {31'd0, valid_o}, 32'd0);
      check("held_cnt", {28'd0, cap_cnt_o}, 32'd2);
      release_key();
      press(8'h5A);
      wait_valid(20, e);
      check("cap3_data", {24'd0, data_o}, 32'h5A);
      check("cap3_cnt", {28'd0, cap_cnt_o}, 32'd3);
      ack_pulse();
      release_key();

      // Sixteen full cycles: count walks 4..15, wraps to 0, ends back at 3.
      for (int i = 0; i < 16; i++) do_capture(8'(8'h10 + i), 4'((3 + i + 1) % 16));
      check("wrap_cnt", {28'd0, cap_cnt_o}, 32'd3);

      // Reset mid-debounce, then in VALID, with the key held throughout.
      press(8'hC3);
      step(4);
      @(negedge clk_i); rst_i = 1'b1;
      step(1);
      check("rstdb_valid", {31'd0, valid_o}, 32'd0);
      check("rstdb_cnt", {28'd0, cap_cnt_o}, 32'd0);
      check("rstdb_data", {24'd0, data_o}, 32'h00);
      @(negedge clk_i); rst_i = 1'b0;
      wait_valid(20, e);
      check("rstdb_recap_lat", e, DB + 3);
      check("rstdb_recap_data", {24'd0, data_o}, 32'hC3);
      check("rstdb_recap_cnt", {28'd0, cap_cnt_o}, 32'd1);
      @(negedge clk_i); rst_i = 1'b1;
      step(1);
      check("rstv_valid", {31'd0, valid_o}, 32'd0);
      check("rstv_cnt", {28'd0, cap_cnt_o}, 32'd0);
      check("rstv_data", {24'd0, data_o}, 32'h00);
      @(negedge clk_i); rst_i = 1'b0;
      wait_valid(20, e);
      check("rstv_recap_valid", {31'd0, valid_o}, 32'd1);
      check("rstv_recap_cnt", {28'd0, cap_cnt_o}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sw_capture.md
SW_CAPTURE -- requirements
Module: sw_capture

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a key press or key release; legal range 2..255.
REQ-002 clk_i  in  1  single system clock (the divided slow clock feeding core).
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 sw_i  in  8  raw slide-switch operand, asynchronous to clk_i.
REQ-005 key_n_i  in  1  raw push-button, active-low, asynchronous and bouncy.
REQ-006 ack_i  in  1  consumer (core) has taken data_o; meaningful only while valid_o=1.
REQ-007 data_o  out  8  captured operand, stable from valid_o rise until the next capture.
REQ-008 valid_o  out  1  captured operand available, level-held until acknowledged.
REQ-009 cap_cnt_o  out  4  count of accepted captures, for the HEX display.

Function
REQ-010 sw_i and key_n_i each SHALL pass through a two-flop synchronizer (sw_s, key_s) before any other use.
REQ-011 FSM states: IDLE, PRESS_DB, VALID, RELEASE_DB.
REQ-012 IDLE: key_s=0 -> PRESS_DB with debounce counter cleared to 0; otherwise stay in IDLE.
REQ-013 PRESS_DB: key_s=1 -> IDLE (bounce rejected, no capture); key_s=0 and counter<DB_CYCLES-1 -> counter+1; key_s=0 and counter=DB_CYCLES-1 -> VALID.
REQ-014 On the PRESS_DB->VALID transition: data_o<=sw_s, valid_o<=1, cap_cnt_o<=cap_cnt_o+1 (mod 16, 15 wraps to 0), all registered in the same edge.
REQ-015 Latency: a key_n_i held low from an edge SHALL produce valid_o=1 exactly DB_CYCLES+3 rising edges later (2 sync + 1 IDLE + DB_CYCLES).
REQ-016 VALID: ack_i=1 -> valid_o<=0 next edge and -> RELEASE_DB with counter cleared; ack_i=0 -> hold all outputs indefinitely.
REQ-017 data_o SHALL NOT change while valid_o=1, regardless of sw_i activity.
REQ-018 RELEASE_DB: key_s=0 -> counter cleared, stay; key_s=1 and counter<DB_CYCLES-1 -> counter+1; key_s=1 and counter=DB_CYCLES-1 -> IDLE.
REQ-019 Holding the key after ack SHALL NOT cause another capture: exactly one capture per debounced press/release pair.
REQ-020 ack_i outside VALID SHALL be ignored.
REQ-021 Key press while in VALID (button already held) SHALL have no effect.
REQ-022 data_o and cap_cnt_o SHALL retain their values after valid_o falls.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 rst_i=1 at an edge SHALL force: state IDLE, debounce counter 0, synchronizer flops sw_s=0x00 and key_s=1 (released), data_o=0x00, valid_o=0, cap_cnt_o=0.
REQ-025 Reset asserted mid-debounce or in VALID SHALL abort without capture or count increment; after release, a still-held key SHALL be treated as a new press.

Structure
REQ-026 State enum (capture_state_t), DB counter width constant (DB_W=8) and data width constant (DATA_W=8) SHALL live in package affine.
REQ-027 One sub-module, sync2, SHALL implement the parameter-width two-flop synchronizer and be instantiated for sw_i and key_n_i.
REQ-028 The top-level SHALL connect data_o to core ext_data_i and cap_cnt_o to a spare HEX digit.

Verification (DB_CYCLES=4 in sim)
REQ-029 sw_i=0xA5, key_n_i low for 20 cycles -> valid_o rises 7 edges after first low sample, data_o=0xA5, cap_cnt_o=1.
REQ-030 key_n_i low 2 cycles, high, low 2 cycles (bounce) -> valid_o stays 0, cap_cnt_o stays 0.
REQ-031 Capture 0x3C, hold ack_i=0 for 50 cycles while sw_i toggles -> data_o stays 0x3C, valid_o stays 1; ack_i pulse -> valid_o=0 next edge.
REQ-032 Key held 100 cycles across ack -> exactly one capture; release 4 stable cycles then new press -> second capture, cap_cnt_o=2.
REQ-033 16 complete press/ack/release cycles -> cap_cnt_o returns to 0 on the 16th capture.
REQ-034 rst_i pulsed during PRESS_DB and again during VALID -> all outputs at reset values, no count increment, held key captured again after reset release.
